fp16_accum_ctrl: RTL and testbench

- Sequencing stage wrapped around the team's combinational half-precision adder. It sits both upstream and downstream of that adder.
- Upstream role: accepts a packet-delimited stream of fp16 operands with valid/ready handshake, and drives the adder's two operand inputs with {running accumulator, incoming operand}.
- Downstream role: registers the adder's sum back into the accumulator every accepted beat.
- On the last beat, presents the packet total, beat count and overflow flag to a consumer through a valid/ready output handshake.

---
 rtl/fp16_accum_ctrl.sv | 91 +++++++++
 tb/tb_fp16_accum_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_accum_ctrl.sv
// Packet accumulator sequencing an external combinational fp16 adder.
// Define FP_ACC_SAT_EN to clamp inf/NaN accumulator writes to the largest finite value.
module fp16_accum_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clock_80,
  input  logic             reset_80,
  input  logic             in_valid_80,
  output logic             in_ready_80,
  input  logic [15:0]      in_data_80,
  input  logic             in_last_80,
  output logic [15:0]      add_a_80,
  output logic [15:0]      add_b_80,
  input  logic [15:0]      add_sum_80,
  output logic             out_valid_80,
  input  logic             out_ready_80,
  output logic [15:0]      out_data_80,
  output logic [CNT_W-1:0] out_count_80,
  output logic             out_ovf_80
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [15:0]      acc;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             in_fire, out_fire;
  logic [15:0]      raw_val;
  logic             raw_ovf;

  function automatic logic [15:0] sat_val(input logic [15:0] v);
`ifdef FP_ACC_SAT_EN
    return (v[14:10] == 5'h1F) ? {v[15], 15'h7BFF} : v;
`else
    return v;
`endif
  endfunction

  assign in_ready_80  = !reset_80 && (state != HOLD);
  assign out_valid_80 = (state == HOLD);
  assign in_fire      = in_valid_80 && in_ready_80;
  assign out_fire     = out_valid_80 && out_ready_80;

  assign add_a_80     = acc;
  assign add_b_80     = in_data_80;
  assign out_data_80  = acc;
  assign out_count_80 = count;
  assign out_ovf_80   = ovf;

  // The first beat of a packet bypasses the adder so stale acc never leaks in.
  assign raw_val = (state == IDLE) ? in_data_80 : add_sum_80;
  assign raw_ovf = (raw_val[14:10] == 5'h1F);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: if (in_fire) state_nxt = in_last_80 ? HOLD : ACC;
      HOLD:      if (out_fire) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_80) begin
    if (reset_80) begin
      state <= IDLE;
      acc   <= 16'h0000;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        acc <= sat_val(raw_val);
        if (state == IDLE) begin
          count <= CNT_W'(1);
          ovf   <= raw_ovf;
        end else begin
          count <= (count == CNT_MAX) ? count : count + 1'b1;
          ovf   <= ovf | raw_ovf;
        end
      end else if (out_fire) begin
        count <= '0;
        ovf   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp16_accum_ctrl.sv
// Randomized self-checking bench for fp16_accum_ctrl with a packet-level reference model
// and an ideal truncating fp16 adder driving add_sum_80.
module tb_fp16_accum_ctrl;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [15:0]      in_data;
  logic [15:0]      add_a, add_b, add_sum;
  logic             out_valid, out_ready, out_ovf;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_err = 0;
  logic cmp_en  = 1'b0;
  logic rand_rdy = 1'b0;
  logic dir_rdy  = 1'b0;

  fp16_accum_ctrl #(.CNT_W(CNT_W)) dut (
    .clock_80    (clk),
    .reset_80    (rst),
    .in_valid_80 (in_valid),
    .in_ready_80 (in_ready),
    .in_data_80  (in_data),
    .in_last_80  (in_last),
    .add_a_80    (add_a),
    .add_b_80    (add_b),
    .add_sum_80  (add_sum),
    .out_valid_80(out_valid),
    .out_ready_80(out_ready),
    .out_data_80 (out_data),
    .out_count_80(out_count),
    .out_ovf_80  (out_ovf)
  );

  always #5 clk = ~clk;

  // ---------------- ideal fp16 arithmetic (real-valued, truncating) ----------------
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else        repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_to_real(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real m = real'(h[9:0]);
    real r;
    if (e == 0) r = m * pow2(-24);
    else        r = (1.0 + m / 1024.0) * pow2(e - 15);
    return h[15] ? -r : r;
  endfunction

  function automatic int trunc_int(input real v);
    int m = int'(v);
    if (real'(m) > v) m = m - 1;
    return m;
  endfunction

  function automatic logic [15:0] real_to_fp(input real x);
    logic s = (x < 0.0);
    real  a = s ? -x : x;
    int   e;
    int   m;
    if (a >= 65536.0) return {s, 5'h1F, 10'h000};
    if (a < pow2(-14)) begin
      m = trunc_int(a * pow2(24));
      return {s, 5'h00, m[9:0]};
    end
    e = 30;
    while (e > 1 && a < pow2(e - 15)) e = e - 1;
    m = trunc_int((a / pow2(e - 15) - 1.0) * 1024.0);
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    if (a[14:10] == 5'h1F) return a;
    if (b[14:10] == 5'h1F) return b;
    return real_to_fp(fp_to_real(a) + fp_to_real(b));
  endfunction

  function automatic logic [15:0] acc_store(input logic [15:0] v);
`ifdef FP_ACC_SAT_EN
    if (v[14:10] == 5'h1F) return {v[15], 15'h7BFF};
`endif
    return v;
  endfunction

  assign add_sum = fp_add(add_a, add_b);

  // ---------------- packet-level reference model ----------------
  // m_cnt == 0 means the next accepted beat opens a fresh packet.
  logic [15:0] m_acc = 16'h0000;
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_raw;

  assign m_raw = (m_cnt == 0) ? in_data : fp_add(m_acc, in_data);

  always @(posedge clk) begin
    if (rst) begin
      m_acc  <= 16'h0000;
      m_cnt  <= 0;
      m_ovf  <= 1'b0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done <= 1'b0;
        m_cnt  <= 0;
        m_ovf  <= 1'b0;
      end
    end else if (in_valid) begin
      m_acc  <= acc_store(m_raw);
      m_cnt  <= (m_cnt == 0) ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
      m_ovf  <= ((m_cnt == 0) ? 1'b0 : m_ovf) | (m_raw[14:10] == 5'h1F);
      m_done <= in_last;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",  32'(in_ready),  32'(!rst && !m_done));
      check("out_valid", 32'(out_valid), 32'(m_done));
      check("add_a",     32'(add_a),     32'(m_acc));
      check("add_b",     32'(add_b),     32'(in_data));
      check("out_data",  32'(out_data),  32'(m_acc));
      check("out_count", 32'(out_count), 32'(m_cnt));
      check("out_ovf",   32'(out_ovf),   32'(m_ovf));
    end
  end

  // Single driver for out_ready: random consumer or directed level.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : dir_rdy;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_result();
    @(posedge clk);
    #1;
    dir_rdy = 1'b1;
    @(posedge clk);
    #1;
    dir_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1111;
    in_last  = 1'b0;

    // Reset held two edges with a beat offered.
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Pin the adder model itself.
    check("pin_add_3p0",  32'(fp_add(16'h3E00, 16'h3E00)), 32'h4200);
    check("pin_add_4p5",  32'(fp_add(16'h4200, 16'h3E00)), 32'h4480);
    check("pin_add_ovf",  32'(fp_add(16'h7BFF, 16'h7BFF)), 32'h7C00);
    check("pin_add_zero", 32'(fp_add(16'h0000, 16'hC500)), 32'hC500);

    // Two-beat packet: 1.5 + 1.5.
    @(posedge clk);
    #1;
    send(16'h3E00, 1'b0);
    send(16'h3E00, 1'b1);
    @(negedge clk);
    check("two_valid", 32'(out_valid), 32'd1);
    check("two_data",  32'(out_data),  32'h4200);
    check("two_count", 32'(out_count), 32'd2);
    check("two_ovf",   32'(out_ovf),   32'd0);
    release_result();

    // Three-beat packet held for five cycles.
    send(16'h3E00, 1'b0);
    send(16'h3E00, 1'b0);
    send(16'h3E00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("three_valid", 32'(out_valid), 32'd1);
      check("three_data",  32'(out_data),  32'h4480);
      check("three_count", 32'(out_count), 32'd3);
    end
    release_result();
    @(negedge clk);
    check("three_idle_ready", 32'(in_ready),  32'd1);
    check("three_idle_valid", 32'(out_valid), 32'd0);

    // Single-beat packet with a beat offered during HOLD.
    @(posedge clk);
    #1;
    send(16'hC500, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("single_ready", 32'(in_ready),  32'd0);
      check("single_data",  32'(out_data),  32'hC500);
      check("single_count", 32'(out_count), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    release_result();

    // Overflow packet.
    send(16'h7BFF, 1'b0);
    send(16'h7BFF, 1'b1);
    @(negedge clk);
    check("ovf_flag", 32'(out_ovf), 32'd1);
`ifdef FP_ACC_SAT_EN
    check("ovf_data", 32'(out_data), 32'h7BFF);
`else
    check("ovf_exp",  32'(out_data[14:10]), 32'h1F);
`endif
    release_result();

    // Reset mid-packet, then a fresh single-beat packet.
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_count", 32'(out_count), 32'd0);
    check("midrst_ready", 32'(in_ready),  32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(16'h4000, 1'b1);
    @(negedge clk);
    check("midrst_data",  32'(out_data),  32'h4000);
    check("midrst_cnt1",  32'(out_count), 32'd1);
    release_result();

    // Count saturation: 258 zero beats.
    for (int i = 0; i < 258; i++) send(16'h0000, (i == 257));
    @(negedge clk);
    check("sat_count", 32'(out_count), 32'(CNT_MAX));
    check("sat_data",  32'(out_data),  32'h0000);
    release_result();

    // Randomized packets with random gaps and random consumer backpressure.
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len = int'($urandom_range(1, 8));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send(16'($urandom), (b == len - 1));
      end
    end
    rand_rdy = 1'b0;
    dir_rdy  = 1'b1;
    wait_valid();
    repeat (4) @(posedge clk);
    #1;
    dir_rdy = 1'b0;
    @(negedge clk);
    check("drain_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
